lbus_master: RTL and testbench

Local-bus initiator that turns single core-side load/store requests into local-bus accesses. It drives `sel`/`addr`/`we`/`wdata` toward peripheral register blocks such as GPIO, captures `rdata` after a fixed read latency, aligns and extends the read data, and returns one response per request. It sits between the core's load/store unit and the peripheral address decoder.

---
 rtl/lbus_master_pkg.sv | 47 ++++
 rtl/lbus_master_if.sv | 42 ++++
 rtl/lbus_rdext.sv | 27 ++
 rtl/lbus_master.sv | 164 ++++++++++++++++
 tb/tb_lbus_master.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lbus_master_pkg.sv
// Shared definitions for the local-bus initiator: access size codes, byte-lane
// write-enable encodings, FSM state encoding and default widths.
package lbus_master_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int AWIDTH_DEFAULT = 12;
    localparam int LAT_W          = 3;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    localparam logic [2:0] WE_READ = 3'b000;
    localparam logic [2:0] WE_BYTE = 3'b001;
    localparam logic [2:0] WE_HALF = 3'b010;
    localparam logic [2:0] WE_WORD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // A request is rejected when its size is illegal or it straddles its natural alignment.
    function automatic logic req_is_bad(size_e size, logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] we_for_size(size_e size);
        case (size)
            SIZE_BYTE: return WE_BYTE;
            SIZE_HALF: return WE_HALF;
            SIZE_WORD: return WE_WORD;
            default:   return WE_READ;
        endcase
    endfunction

endpackage

// File: rtl/lbus_master_if.sv
// Core-side request/response handshake plus local-bus signals of the initiator.
// The master modport is the initiator's view; slave is the environment's view.
interface lbus_master_if
    import lbus_master_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int AWIDTH = AWIDTH_DEFAULT
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [AWIDTH-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    logic              sel;
    logic [AWIDTH-1:0] addr;
    logic [2:0]        we;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   rdata;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output sel, addr, we, wdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  sel, addr, we, wdata
    );

endinterface

// File: rtl/lbus_rdext.sv
// Combinational read aligner: moves the addressed lane down to bit 0, then
// masks to the access size and zero- or sign-extends.
module lbus_rdext
    import lbus_master_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  size_e           size,
    input  logic            uns,
    output logic [XLEN-1:0] ext
);
    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        ext = shifted;
        case (size)
            SIZE_BYTE: ext = {{(XLEN-8){~uns & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: ext = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
            default:   ext = shifted;
        endcase
    end

endmodule

// File: rtl/lbus_master.sv
// Local-bus initiator: one outstanding load/store, fixed read latency RD_LAT.
// Define LBUS_MASTER_POSTED_WRITE_EN to complete aligned writes without a response.
module lbus_master
    import lbus_master_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int AWIDTH = AWIDTH_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    lbus_master_if.master bus
);
    state_e            state_reg, state_next;
    logic [LAT_W-1:0]  cnt_reg, cnt_next;

    logic              wr_reg, wr_next;
    size_e             size_reg, size_next;
    logic              uns_reg, uns_next;
    logic [1:0]        off_reg, off_next;

    logic              sel_reg, sel_next;
    logic [AWIDTH-1:0] addr_reg, addr_next;
    logic [2:0]        we_reg, we_next;
    logic [XLEN-1:0]   wdata_reg, wdata_next;
    logic              req_ready_reg, req_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [XLEN-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;

    logic [XLEN-1:0]   rd_ext;
    size_e             req_size_e;

    assign req_size_e = size_e'(bus.req_size);

    lbus_rdext #(.XLEN(XLEN)) u_rdext (
        .rdata (bus.rdata),
        .addr  (off_reg),
        .size  (size_reg),
        .uns   (uns_reg),
        .ext   (rd_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            wr_reg        <= 1'b0;
            size_reg      <= SIZE_BYTE;
            uns_reg       <= 1'b0;
            off_reg       <= 2'b00;
            sel_reg       <= 1'b0;
            addr_reg      <= '0;
            we_reg        <= WE_READ;
            wdata_reg     <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            wr_reg        <= wr_next;
            size_reg      <= size_next;
            uns_reg       <= uns_next;
            off_reg       <= off_next;
            sel_reg       <= sel_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            wdata_reg     <= wdata_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // Every output register is loaded from the next state so that bus and
    // handshake outputs change exactly on entry to the state they belong to.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        wr_next        = wr_reg;
        size_next      = size_reg;
        uns_next       = uns_reg;
        off_next       = off_reg;
        sel_next       = 1'b0;
        addr_next      = addr_reg;
        we_next        = WE_READ;
        wdata_next     = wdata_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_next   = bus.req_write;
                    size_next = req_size_e;
                    uns_next  = bus.req_unsigned;
                    off_next  = bus.req_addr[1:0];
                    if (req_is_bad(req_size_e, bus.req_addr[1:0])) begin
                        state_next     = ST_RESP;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = '0;
                    end else begin
                        state_next = ST_ACCESS;
                        sel_next   = 1'b1;
                        addr_next  = {bus.req_addr[AWIDTH-1:2], 2'b00};
                        if (bus.req_write) begin
                            we_next    = we_for_size(req_size_e);
                            wdata_next = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
                        end
                    end
                end
            end

            ST_ACCESS: begin
                if (wr_reg) begin
`ifdef LBUS_MASTER_POSTED_WRITE_EN
                    state_next = ST_IDLE;
`else
                    state_next     = ST_RESP;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = '0;
`endif
                end else begin
                    cnt_next   = LAT_W'(RD_LAT);
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_reg == LAT_W'(1)) begin
                    state_next     = ST_RESP;
                    rsp_rdata_next = rd_ext;
                    rsp_err_next   = 1'b0;
                end else begin
                    cnt_next = cnt_reg - LAT_W'(1);
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase

        req_ready_next = (state_next == ST_IDLE);
        rsp_valid_next = (state_next == ST_RESP);
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.sel       = sel_reg;
    assign bus.addr      = addr_reg;
    assign bus.we        = we_reg;
    assign bus.wdata     = wdata_reg;

endmodule

// File: tb/tb_lbus_master.sv
// Directed plus randomized bench for lbus_master; a second instance with
// RD_LAT = 3 checks the longer read latency.
module tb_lbus_master;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;

    always #5 clk = ~clk;

    lbus_master_if #(.XLEN(32), .AWIDTH(12)) bus ();
    lbus_master_if #(.XLEN(32), .AWIDTH(12)) bus3 ();

    lbus_master #(.XLEN(32), .AWIDTH(12), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lbus_master #(.XLEN(32), .AWIDTH(12), .RD_LAT(3)) dut_l3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rules: legality, lane enables and load extension by arithmetic.
    function automatic bit exp_err(input int size, input logic [11:0] a);
        return (size == 3) || (size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [2:0] exp_we(input int size);
        case (size)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input int size, input bit uns,
                                             input logic [11:0] a, input logic [31:0] rd);
        int v;
        logic [31:0] lane;
        lane = rd >> (8 * int'(a[1:0]));
        if (size == 0) begin
            v = int'(lane & 32'hFF);
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = int'(lane & 32'hFFFF);
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = int'(lane);
        end
        return 32'(v);
    endfunction

    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic run_txn(input bit wr, input int size, input bit uns, input logic [11:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int bp);
        bit          err;
        bit          posted;
        int          rsp_k;
        int          last_k;
        logic [31:0] exp_rd;
        err    = exp_err(size, a);
        posted = 1'b0;
`ifdef LBUS_MASTER_POSTED_WRITE_EN
        posted = wr && !err;
`endif
        rsp_k  = err ? 1 : (wr ? 2 : 2 + RD_LAT);
        last_k = posted ? 2 : rsp_k;
        exp_rd = (err || wr) ? 32'h0 : exp_load(size, uns, a, rd);

        chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = 2'(size);
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.rsp_ready    = 1'b0;
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = 12'($urandom);
        bus.req_wdata    = $urandom;

        for (int k = 1; k <= last_k; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            bus.rdata = (k == 1 + RD_LAT) ? rd : $urandom;
            chk("sel", 32'(bus.sel), 32'(k == 1 && !err));
            if (k == 1 && !err) begin
                chk("addr", 32'(bus.addr), 32'({a[11:2], 2'b00}));
                chk("we_access", 32'(bus.we), 32'(wr ? exp_we(size) : 3'b000));
                if (wr) chk("wdata", bus.wdata, 32'(wd << (8 * int'(a[1:0]))));
            end else begin
                chk("we_idle", 32'(bus.we), 32'd0);
            end
            chk("rsp_valid_timing", 32'(bus.rsp_valid), 32'(!posted && k == rsp_k));
            chk("req_ready_busy", 32'(bus.req_ready), 32'(posted && k == 2));
        end

        if (!posted) begin
            chk("rsp_err", 32'(bus.rsp_err), 32'(err));
            chk("rsp_rdata", bus.rsp_rdata, exp_rd);
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                bus.rdata = $urandom;
                chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("bp_rsp_rdata", bus.rsp_rdata, exp_rd);
                chk("bp_rsp_err", 32'(bus.rsp_err), 32'(err));
                chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
                chk("bp_sel", 32'(bus.sel), 32'd0);
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            chk("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
            chk("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
        end
        n_txn++;
        $display("[TB] txn %0d wr=%0d size=%0d uns=%0d addr=%h wdata=%h rd=%h bp=%0d err=%0d exp_rdata=%h",
                 n_txn, wr, size, uns, a, wd, rd, bp, err, exp_rd);
    endtask

    initial begin
        bit          r_wr;
        int          r_size;
        logic [11:0] r_addr;

        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0;   bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;  bus.rdata = '0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_size = 2'd0;
        bus3.req_unsigned = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
        bus3.rsp_ready = 1'b0; bus3.rdata = '0;

        // Reset values while rst is held.
        @(posedge clk); #1;
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_txn(1'b1, 2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 0);
        run_txn(1'b1, 0, 1'b0, 12'h013, 32'h000000A5, 32'h0, 0);
        run_txn(1'b0, 0, 1'b0, 12'h012, 32'h0, 32'h0080_0000, 0);
        run_txn(1'b0, 0, 1'b1, 12'h012, 32'h0, 32'h0080_0000, 0);
        run_txn(1'b0, 1, 1'b0, 12'h011, 32'h0, 32'h1234_5678, 0);
        run_txn(1'b0, 2, 1'b0, 12'h002, 32'h0, 32'h1234_5678, 0);
        run_txn(1'b0, 3, 1'b0, 12'h020, 32'h0, 32'h1234_5678, 0);
        run_txn(1'b1, 1, 1'b0, 12'h031, 32'h0000_BEEF, 32'h0, 1);
        run_txn(1'b0, 1, 1'b0, 12'h042, 32'h0, 32'h8001_7FFF, 5);
        run_txn(1'b1, 1, 1'b0, 12'h042, 32'hFFFF_CAFE, 32'h0, 0);
        run_txn(1'b1, 2, 1'b0, 12'h044, 32'h0BAD_F00D, 32'h0, 0);

        // Longer read latency on the second instance: response at T+5.
        chk("l3_req_ready", 32'(bus3.req_ready), 32'd1);
        bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_size = 2'd0;
        bus3.req_unsigned = 1'b0; bus3.req_addr = 12'h012;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            bus3.rdata = (k == 4) ? 32'h0080_0000 : $urandom;
            chk("l3_sel", 32'(bus3.sel), 32'(k == 1));
            chk("l3_rsp_valid_timing", 32'(bus3.rsp_valid), 32'(k == 5));
        end
        chk("l3_rsp_rdata", bus3.rsp_rdata, exp_load(0, 1'b0, 12'h012, 32'h0080_0000));
        chk("l3_rsp_err", 32'(bus3.rsp_err), 32'd0);
        bus3.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus3.rsp_ready = 1'b0;
        chk("l3_rsp_valid_after_hs", 32'(bus3.rsp_valid), 32'd0);
        $display("[TB] txn l3 signed byte load addr=012 rd=00800000 exp_rdata=ffffff80");

        // Randomized traffic, biased toward aligned addresses.
        for (int n = 0; n < 60; n++) begin
            r_wr   = 1'($urandom);
            r_size = int'($urandom_range(0, 3));
            r_addr = 12'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (r_size == 1) r_addr[0] = 1'b0;
                if (r_size == 2) r_addr[1:0] = 2'b00;
            end
            run_txn(r_wr, r_size, 1'($urandom), r_addr, $urandom, $urandom,
                    int'($urandom_range(0, 3)));
        end

        // Reset during WAIT drops the read with no response.
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 12'h020; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rstw_sel_access", 32'(bus.sel), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstw_sel", 32'(bus.sel), 32'd0);
        chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstw_addr", 32'(bus.addr), 32'd0);
        chk("rstw_we", 32'(bus.we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            bus.rdata = $urandom;
            chk("rstw_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("rstw_req_ready", 32'(bus.req_ready), 32'd1);
            chk("rstw_no_sel", 32'(bus.sel), 32'd0);
        end
        $display("[TB] txn reset-in-wait addr=020 dropped");

        run_txn(1'b0, 2, 1'b0, 12'h024, 32'h0, 32'hC001_D00D, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
